// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the direct-mapped instruction cache controller:
// bus command encodings, FSM state encoding, geometry defaults and an
// address-alignment helper.
package icache_ctrl_pkg;

  // Default geometry: 32 lines of one 64-bit word each.
  localparam int NUM_LINES_DEF = 32;
  localparam int IDX_BITS_DEF  = 5;

  // Main-memory bus command encodings.
  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_LOAD = 2'b01;

  // Miss-handling FSM states.
  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_REQ  = 2'd1,
    IC_WAIT = 2'd2
  } ic_state_e;

  // Clear the byte offset so the address names a whole 64-bit line.
  function automatic logic [63:0] line_align(input logic [63:0] addr);
    return {addr[63:3], 3'b000};
  endfunction

endpackage

// File: rtl/icache_ctrl_mem.sv
// Line storage for the instruction cache: per-line valid bits, tag and data
// arrays. One combinational read port (zero-latency hit path) and one
// synchronous write port used by fills. Reset clears only the valid bits;
// tag and data contents are meaningless until their line is marked valid.
module icache_ctrl_mem
  import icache_ctrl_pkg::*;
#(
  parameter int NUM_LINES = NUM_LINES_DEF,
  parameter int IDX_BITS  = IDX_BITS_DEF,
  parameter int TAG_BITS  = 61 - IDX_BITS_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [63:0]         rd_data,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [63:0]         wr_data
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] valid_d;
  logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
  logic [63:0]          data_mem [NUM_LINES];

  // A fill sets the valid bit of its line; nothing else ever clears one.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_valid
      assign valid_d[gi] = valid_q[gi] | (wr_en && (wr_idx == IDX_BITS'(gi)));
    end
  endgenerate

  // Valid bits are the only reset state in the storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Fill writes overwrite the indexed line unconditionally.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller between the fetch stage and the
// tagged main-memory bus. Hits are answered combinationally; a miss is filled
// with a single outstanding BUS_LOAD. A redirect during a miss does not cancel
// the fill, and a fill is never bypassed to the fetch outputs.
// Optional feature: define ICACHE_STATS_EN to add saturating hit_count and
// miss_count outputs.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int NUM_LINES = NUM_LINES_DEF,
  parameter int IDX_BITS  = IDX_BITS_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] proc2Icache_addr,
  output logic [63:0] Icache2proc_data,
  output logic [1:0]  Icache_valid,
  output logic [1:0]  Icache2mem_command,
  output logic [63:0] Icache2mem_addr,
  input  logic [3:0]  mem2Icache_response,
  input  logic [63:0] mem2Icache_data,
  input  logic [3:0]  mem2Icache_tag
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int TAG_BITS = 64 - 3 - IDX_BITS;

  ic_state_e     state_q, state_d;
  logic [63:0]   miss_addr_q, miss_addr_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [3:0]    wait_tag_q, wait_tag_d;

  logic [IDX_BITS-1:0] cur_idx;
  logic [TAG_BITS-1:0] cur_tag;
  logic                rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [63:0]         rd_data;
  logic                hit;
  logic                fill_en;
  logic                unused_addr_bits;

  assign cur_idx = proc2Icache_addr[3+IDX_BITS-1:3];
  assign cur_tag = proc2Icache_addr[63:3+IDX_BITS];

  // Instruction bits [1:0] are byte offsets within an instruction.
  assign unused_addr_bits = ^proc2Icache_addr[1:0];

  icache_ctrl_mem #(
    .NUM_LINES (NUM_LINES),
    .IDX_BITS  (IDX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_mem (
    .clock    (clock),
    .reset    (reset),
    .rd_idx   (cur_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_en),
    .wr_idx   (miss_addr_q[3+IDX_BITS-1:3]),
    .wr_tag   (miss_addr_q[63:3+IDX_BITS]),
    .wr_data  (mem2Icache_data)
  );

  // A returning tag only counts in WAIT; a zero wait tag (after reset) never matches.
  assign fill_en = (state_q == IC_WAIT) && (wait_tag_q != 4'd0) &&
                   (mem2Icache_tag == wait_tag_q);

  // Hit path: zero latency, always reflects the current fetch address only.
  assign hit              = rd_valid && (rd_tag == cur_tag);
  assign Icache_valid     = {hit, hit & ~proc2Icache_addr[2]};
  assign Icache2proc_data = hit ? rd_data : 64'd0;

  assign Icache2mem_command = cmd_q;
  assign Icache2mem_addr    = miss_addr_q;

  // Next-state logic for the miss FSM and its registered bus outputs.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    cmd_d       = cmd_q;
    wait_tag_d  = wait_tag_q;
    case (state_q)
      IC_IDLE: begin
        if (!hit) begin
          miss_addr_d = line_align(proc2Icache_addr);
          cmd_d       = BUS_LOAD;
          state_d     = IC_REQ;
        end
      end
      IC_REQ: begin
        if (mem2Icache_response != 4'd0) begin
          wait_tag_d = mem2Icache_response;
          cmd_d      = BUS_NONE;
          state_d    = IC_WAIT;
        end
      end
      IC_WAIT: begin
        if (fill_en) begin
          state_d = IC_IDLE;
        end
      end
      default: begin
        cmd_d   = BUS_NONE;
        state_d = IC_IDLE;
      end
    endcase
  end

  // FSM registers; reset drops any in-flight transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IC_IDLE;
      miss_addr_q <= 64'd0;
      cmd_q       <= BUS_NONE;
      wait_tag_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      cmd_q       <= cmd_d;
      wait_tag_q  <= wait_tag_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Saturating counters: IDLE cycles that hit, and IDLE->REQ transitions.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == IC_IDLE && hit && hit_cnt_q != 32'hFFFF_FFFF) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (state_q == IC_IDLE && !hit && miss_cnt_q != 32'hFFFF_FFFF) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed testbench for icache_ctrl. Inputs are driven on the falling edge,
// outputs sampled 1ns later; the rising edge is the active edge.
// Define ICACHE_STATS_EN to also exercise the statistics counters.
module tb_icache_ctrl;

  localparam logic [1:0]  C_NONE = 2'b00;
  localparam logic [1:0]  C_LOAD = 2'b01;
  localparam logic [63:0] D0   = 64'h0123_4567_89ab_cdef;
  localparam logic [63:0] D1   = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D2   = 64'haaaa_bbbb_cccc_dddd;
  localparam logic [63:0] JUNK = 64'hdead_beef_cafe_f00d;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] addr  = 64'd0;
  logic [63:0] data_o;
  logic [1:0]  valid_o;
  logic [1:0]  cmd_o;
  logic [63:0] maddr_o;
  logic [3:0]  resp  = 4'd0;
  logic [63:0] mdata = 64'd0;
  logic [3:0]  mtag  = 4'd0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  icache_ctrl dut (
    .clock               (clock),
    .reset               (reset),
    .proc2Icache_addr    (addr),
    .Icache2proc_data    (data_o),
    .Icache_valid        (valid_o),
    .Icache2mem_command  (cmd_o),
    .Icache2mem_addr     (maddr_o),
    .mem2Icache_response (resp),
    .mem2Icache_data     (mdata),
    .mem2Icache_tag      (mtag)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count           (hit_count),
    .miss_count          (miss_count)
`endif
  );

  task automatic step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; addr = 64'd0; resp = 4'd0; mtag = 4'd0; mdata = 64'd0;
    step(); step(); #1;
    vectors++; if (valid_o !== 2'b00) begin miscompares++; $display("FAIL rst_valid: got %b want 00", valid_o); end
    vectors++; if (data_o !== 64'd0) begin miscompares++; $display("FAIL rst_data: got %h want 0", data_o); end
    vectors++; if (cmd_o !== C_NONE) begin miscompares++; $display("FAIL rst_cmd: got %b want %b", cmd_o, C_NONE); end
    vectors++; if (maddr_o !== 64'd0) begin miscompares++; $display("FAIL rst_maddr: got %h want 0", maddr_o); end
    $display("[%0t] reset: outputs idle", $time);
  endtask

  task automatic test_fill();
    step(); reset = 1'b0; addr = 64'h0; #1;
    vectors++; if (valid_o !== 2'b00) begin miscompares++; $display("FAIL s1_miss_valid: got %b want 00", valid_o); end
    step(); #1;
    vectors++; if (cmd_o !== C_LOAD) begin miscompares++; $display("FAIL s1_req_cmd: got %b want %b", cmd_o, C_LOAD); end
    vectors++; if (maddr_o !== 64'h0) begin miscompares++; $display("FAIL s1_req_addr: got %h want 0", maddr_o); end
    resp = 4'd3;
    step(); resp = 4'd0; #1;
    vectors++; if (cmd_o !== C_NONE) begin miscompares++; $display("FAIL s1_wait_cmd: got %b want %b", cmd_o, C_NONE); end
    step(); mtag = 4'd3; mdata = D0; #1;
    vectors++; if (valid_o !== 2'b00) begin miscompares++; $display("FAIL s1_no_bypass: got %b want 00", valid_o); end
    step(); mtag = 4'd0; mdata = 64'd0; #1;
    vectors++; if (valid_o !== 2'b11) begin miscompares++; $display("FAIL s1_hit_valid: got %b want 11", valid_o); end
    vectors++; if (data_o !== D0) begin miscompares++; $display("FAIL s1_hit_data: got %h want %h", data_o, D0); end
    vectors++; if (cmd_o !== C_NONE) begin miscompares++; $display("FAIL s1_idle_cmd: got %b want %b", cmd_o, C_NONE); end
    $display("[%0t] fill 0x0 tag 3 -> data %h", $time, data_o);
  endtask

  task automatic test_hit_high();
    step(); addr = 64'h4; #1;
    vectors++; if (valid_o !== 2'b10) begin miscompares++; $display("FAIL s2_valid_4: got %b want 10", valid_o); end
    vectors++; if (data_o !== D0) begin miscompares++; $display("FAIL s2_data_4: got %h want %h", data_o, D0); end
    addr = 64'h7; #1;
    vectors++; if (valid_o !== 2'b10) begin miscompares++; $display("FAIL s2_valid_7: got %b want 10", valid_o); end
    addr = 64'h3; #1;
    vectors++; if (valid_o !== 2'b11) begin miscompares++; $display("FAIL s2_valid_3: got %b want 11", valid_o); end
    addr = 64'h4;
    step(); #1;
    vectors++; if (cmd_o !== C_NONE) begin miscompares++; $display("FAIL s2_cmd: got %b want %b", cmd_o, C_NONE); end
    $display("[%0t] hit 0x4 -> valid %b", $time, valid_o);
  endtask

  task automatic test_retry();
    step(); addr = 64'h8; #1;
    vectors++; if (valid_o !== 2'b00) begin miscompares++; $display("FAIL s3_miss_valid: got %b want 00", valid_o); end
    for (int i = 0; i < 4; i++) begin
      step();
      mtag  = (i == 0) ? 4'd3 : 4'd0;
      mdata = (i == 0) ? JUNK : 64'd0;
      #1;
      vectors++; if (cmd_o !== C_LOAD) begin miscompares++; $display("FAIL s3_load_held[%0d]: got %b want %b", i, cmd_o, C_LOAD); end
      vectors++; if (maddr_o !== 64'h8) begin miscompares++; $display("FAIL s3_req_addr[%0d]: got %h want 8", i, maddr_o); end
      if (i > 0) begin
        vectors++; if (valid_o !== 2'b00) begin miscompares++; $display("FAIL s3_req_tag_ignored[%0d]: got %b want 00", i, valid_o); end
      end
      resp = (i == 3) ? 4'd5 : 4'd0;
    end
    step(); resp = 4'd0; mtag = 4'd2; mdata = JUNK; #1;
    vectors++; if (cmd_o !== C_NONE) begin miscompares++; $display("FAIL s3_wait_cmd: got %b want %b", cmd_o, C_NONE); end
    step(); mtag = 4'd0; mdata = 64'd0; #1;
    vectors++; if (valid_o !== 2'b00) begin miscompares++; $display("FAIL s3_tag2_ignored: got %b want 00", valid_o); end
    vectors++; if (cmd_o !== C_NONE) begin miscompares++; $display("FAIL s3_single_wait: got %b want %b", cmd_o, C_NONE); end
    step(); mtag = 4'd5; mdata = D1; #1;
    vectors++; if (valid_o !== 2'b00) begin miscompares++; $display("FAIL s3_pre_fill: got %b want 00", valid_o); end
    step(); mtag = 4'd0; mdata = 64'd0; #1;
    vectors++; if (valid_o !== 2'b11) begin miscompares++; $display("FAIL s3_fill_valid: got %b want 11", valid_o); end
    vectors++; if (data_o !== D1) begin miscompares++; $display("FAIL s3_fill_data: got %h want %h", data_o, D1); end
    addr = 64'h0; #1;
    vectors++; if (data_o !== D0) begin miscompares++; $display("FAIL s3_line0_kept: got %h want %h", data_o, D0); end
    $display("[%0t] retry fill 0x8 tag 5 -> data %h", $time, D1);
  endtask

  task automatic test_redirect();
    step(); addr = 64'h100; #1;
    vectors++; if (valid_o !== 2'b00) begin miscompares++; $display("FAIL s4_miss_valid: got %b want 00", valid_o); end
    step(); #1;
    vectors++; if (maddr_o !== 64'h100) begin miscompares++; $display("FAIL s4_req_addr: got %h want 100", maddr_o); end
    resp = 4'd7;
    step(); resp = 4'd0; addr = 64'h0; #1;
    vectors++; if (valid_o !== 2'b11) begin miscompares++; $display("FAIL s4_redirect_valid: got %b want 11", valid_o); end
    vectors++; if (data_o !== D0) begin miscompares++; $display("FAIL s4_redirect_data: got %h want %h", data_o, D0); end
    step(); mtag = 4'd7; mdata = D2; #1;
    vectors++; if (valid_o !== 2'b11) begin miscompares++; $display("FAIL s4_pre_evict: got %b want 11", valid_o); end
    step(); mtag = 4'd0; mdata = 64'd0; #1;
    vectors++; if (valid_o !== 2'b00) begin miscompares++; $display("FAIL s4_evicted: got %b want 00", valid_o); end
    addr = 64'h100; #1;
    vectors++; if (valid_o !== 2'b11) begin miscompares++; $display("FAIL s4_new_valid: got %b want 11", valid_o); end
    vectors++; if (data_o !== D2) begin miscompares++; $display("FAIL s4_new_data: got %h want %h", data_o, D2); end
    step(); #1;
    vectors++; if (cmd_o !== C_NONE) begin miscompares++; $display("FAIL s4_idle_cmd: got %b want %b", cmd_o, C_NONE); end
    $display("[%0t] redirect: 0x100 filled over 0x0", $time);
  endtask

  task automatic test_reset_in_wait();
    step(); addr = 64'h1c; #1;
    vectors++; if (valid_o !== 2'b00) begin miscompares++; $display("FAIL s5_miss_valid: got %b want 00", valid_o); end
    step(); #1;
    vectors++; if (maddr_o !== 64'h18) begin miscompares++; $display("FAIL s5_req_aligned: got %h want 18", maddr_o); end
    resp = 4'd9;
    step(); resp = 4'd0; reset = 1'b1;
    step(); reset = 1'b0; mtag = 4'd9; mdata = JUNK; #1;
    vectors++; if (cmd_o !== C_NONE) begin miscompares++; $display("FAIL s5_rst_cmd: got %b want %b", cmd_o, C_NONE); end
    vectors++; if (maddr_o !== 64'd0) begin miscompares++; $display("FAIL s5_rst_maddr: got %h want 0", maddr_o); end
    addr = 64'h100; #1;
    vectors++; if (valid_o !== 2'b00) begin miscompares++; $display("FAIL s5_100_miss: got %b want 00", valid_o); end
    step(); mtag = 4'd0; mdata = 64'd0; #1;
    vectors++; if (valid_o !== 2'b00) begin miscompares++; $display("FAIL s5_late_tag_ignored: got %b want 00", valid_o); end
    vectors++; if (cmd_o !== C_LOAD) begin miscompares++; $display("FAIL s5_rerequest: got %b want %b", cmd_o, C_LOAD); end
    vectors++; if (maddr_o !== 64'h100) begin miscompares++; $display("FAIL s5_rereq_addr: got %h want 100", maddr_o); end
    addr = 64'h18; #1;
    vectors++; if (valid_o !== 2'b00) begin miscompares++; $display("FAIL s5_18_unwritten: got %b want 00", valid_o); end
    reset = 1'b1;
    $display("[%0t] reset in WAIT: late tag 9 dropped", $time);
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    step(); #1;
    vectors++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin miscompares++; $display("FAIL st_reset: got %0d/%0d want 0/0", hit_count, miss_count); end
    step(); reset = 1'b0; addr = 64'h20;
    step(); #1;
    vectors++; if (miss_count !== 32'd1) begin miscompares++; $display("FAIL st_miss1: got %0d want 1", miss_count); end
    resp = 4'd1;
    step(); resp = 4'd0; mtag = 4'd1; mdata = D1;
    step(); mtag = 4'd0; mdata = 64'd0; #1;
    vectors++; if (hit_count !== 32'd0) begin miscompares++; $display("FAIL st_hit0: got %0d want 0", hit_count); end
    step(); addr = 64'h24;
    step(); addr = 64'h20;
    step(); #1;
    vectors++; if (hit_count !== 32'd3) begin miscompares++; $display("FAIL st_hit3: got %0d want 3", hit_count); end
    vectors++; if (miss_count !== 32'd1) begin miscompares++; $display("FAIL st_miss_final: got %0d want 1", miss_count); end
    $display("[%0t] stats: hits %0d misses %0d", $time, hit_count, miss_count);
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_hit_high();
    test_retry();
    test_redirect();
    test_reset_in_wait();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
